// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and line geometry for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, DONE} arb_state_e;
  typedef enum logic {GNT_IC = 1'b0, GNT_DC = 1'b1} gnt_e;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS) + 2;

  // Byte-offset bits below the line address for a given line size.
  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick between I-cache and D-cache
import mem_arb_pkg::*;

module rr_arb2 (
  input  logic ic_req,
  input  logic dc_req,
  input  gnt_e last,
  output logic valid,
  output gnt_e grant
);

  always_comb begin
    valid = ic_req | dc_req;
    grant = GNT_IC;
    if (ic_req && dc_req) begin
      grant = (last == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (dc_req) begin
      grant = GNT_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache refill and D-cache line bursts
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 1 << (OFFSET_BITS - 2)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              ic_req,
  input  logic [ADDR_W-1:0]                 ic_addr,
  output logic                              ic_rvalid,
  output logic                              ic_done,
  input  logic                              dc_req,
  input  logic                              dc_we,
  input  logic [ADDR_W-1:0]                 dc_addr,
  input  logic [DATA_W-1:0]                 dc_wdata,
  output logic                              dc_wready,
  output logic                              dc_rvalid,
  output logic                              dc_done,
  output logic [$clog2(WORDS_PER_LINE)-1:0] beat,
  output logic [DATA_W-1:0]                 rdata,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic                              mem_re,
  output logic                              mem_we,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_ack
);

  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = offset_bits(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;
  gnt_e              gnt_q, last_q;
  logic              arb_valid;
  gnt_e              arb_grant;
  logic              burst;
  logic              unused_offset;

  assign unused_offset = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

  rr_arb2 u_rr_arb2 (
    .ic_req (ic_req),
    .dc_req (dc_req),
    .last   (last_q),
    .valid  (arb_valid),
    .grant  (arb_grant)
  );

  assign burst = (state_q == IC_RD) || (state_q == DC_RD) || (state_q == DC_WR);
  assign beat  = beat_q;
  assign rdata = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      gnt_q   <= GNT_IC;
      last_q  <= GNT_IC;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arb_valid) begin
        gnt_q  <= arb_grant;
        beat_q <= '0;
        line_q <= (arb_grant == GNT_IC) ? ic_addr[ADDR_W-1:OFF_W] : dc_addr[ADDR_W-1:OFF_W];
      end
      // The counter parks on the last beat; only a new grant rewinds it.
      if (burst && mem_ack && beat_q != LAST_BEAT) begin
        beat_q <= beat_q + 1'b1;
      end
      if (state_q == DONE) begin
        last_q <= gnt_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ic_rvalid = 1'b0;
    dc_rvalid = 1'b0;
    dc_wready = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (arb_grant == GNT_IC) state_d = IC_RD;
          else                     state_d = dc_we ? DC_WR : DC_RD;
        end
      end
      IC_RD: begin
        mem_re    = 1'b1;
        ic_rvalid = mem_ack;
        mem_addr  = {line_q, beat_q, 2'b00};
        if (mem_ack && beat_q == LAST_BEAT) state_d = DONE;
      end
      DC_RD: begin
        mem_re    = 1'b1;
        dc_rvalid = mem_ack;
        mem_addr  = {line_q, beat_q, 2'b00};
        if (mem_ack && beat_q == LAST_BEAT) state_d = DONE;
      end
      DC_WR: begin
        mem_we    = 1'b1;
        dc_wready = mem_ack;
        mem_addr  = {line_q, beat_q, 2'b00};
        mem_wdata = dc_wdata;
        if (mem_ack && beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        ic_done = (gnt_q == GNT_IC);
        dc_done = (gnt_q == GNT_DC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and line-burst sequencer sharing one main-memory port between the instruction-cache refill path and the data-cache allocate/write-back path. It sits between both caches and main memory and converts each granted cache request into a fixed burst of word transfers. A one-cycle `done` pulse returns to the granted requester. Arbitration is round-robin, so neither cache starves the other.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width
- `WORDS_PER_LINE`, 4, words per cache line (power of two, ≥2)

- `CLK`  in  1  system clock
- `RST`  in  1  synchronous, active-high reset
- `ic_req`  in  1  I-cache line-refill request; held until `ic_done`
- `ic_addr`  in  ADDR_W  I-cache miss address (any byte in line)
- `ic_rvalid`  out  1  `mem_rdata` is a valid I-cache beat this cycle
- `ic_done`  out  1  one-cycle pulse: I-cache transaction complete
- `dc_req`  in  1  D-cache request; held until `dc_done`
- `dc_we`  in  1  1 = write-back line, 0 = allocate (read) line
- `dc_addr`  in  ADDR_W  D-cache line address (any byte in line)
- `dc_wdata`  in  DATA_W  write-back word for current `beat`
- `dc_wready`  out  1  current write-back word accepted by memory
- `dc_rvalid`  out  1  `mem_rdata` is a valid D-cache beat this cycle
- `dc_done`  out  1  one-cycle pulse: D-cache transaction complete
- `beat`  out  log2(WORDS_PER_LINE)  word index within line of current beat
- `rdata`  out  DATA_W  read data to both caches (pass-through of `mem_rdata`)
- `mem_addr`  out  ADDR_W  word address to memory
- `mem_wdata`  out  DATA_W  write data to memory
- `mem_re`  out  1  memory read strobe
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ack`  in  1  memory completed current word (may be same cycle as strobe)

## Operation
- States: IDLE, IC_RD, DC_RD, DC_WR, DONE.
- IDLE: with no request, stay in IDLE. One request goes to its state. With both requests, grant the requester not served last. `last` is a 1-bit register that resets to IC, so DC wins the first tie.
- On grant: latch line address (`addr[ADDR_W-1:log2(WORDS_PER_LINE)+2]`), latch `dc_we` for DC grants, clear `beat` to 0.
- Burst states: `mem_addr` = {latched line, `beat`, 2'b00}. Assert `mem_re` (IC_RD/DC_RD) or `mem_we` (DC_WR), holding strobe, address and data stable until `mem_ack`.
- On `mem_ack`: IC_RD asserts `ic_rvalid`; DC_RD asserts `dc_rvalid`; DC_WR asserts `dc_wready`. These are combinational and valid the same cycle. `beat` increments at the clock edge. On ack of beat WORDS_PER_LINE-1, go to DONE.
- `mem_wdata` = `dc_wdata` in DC_WR, otherwise 0.
- DONE: pulse `ic_done` or `dc_done` for the granted side, update `last`, return to IDLE. Requests are ignored during DONE.
- The requester must drop `req` in the cycle after `done`. Otherwise it is re-arbitrated as a new request.
- Changes to `ic_addr`/`dc_addr`/`dc_we` after grant are ignored.

## Timing
- Reset: state IDLE, `beat`=0, `last`=IC. All outputs are 0: strobes, valids, readies, dones, `mem_addr`, `mem_wdata`, `beat`.
- A request seen in IDLE at edge N gives a strobe in cycle N+1 (one cycle grant latency).
- Zero-wait memory (ack with strobe): 4 beat cycles, then `done` in the 5th cycle after grant. Req-to-done is 5 cycles; IDLE is re-entered on cycle 6.
- Wait states: strobe remains high across non-ack cycles. `beat`, `mem_addr` and `mem_wdata` are unchanged.
- `mem_ack` outside a burst state is ignored.
- `RST` mid-burst: the next cycle is in reset state and the transaction is abandoned. The requester restarts from beat 0.
- `beat` wraps only through a new grant, never via the counter inside a transaction.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, IC_RD, DC_RD, DC_WR, DONE), grant enum (GNT_IC, GNT_DC), `OFFSET_BITS` constant derived from WORDS_PER_LINE.
- One sub-module `rr_arb2`: 2-way round-robin pick from {`ic_req`, `dc_req`, `last`}. It is combinational, and `last` is held in the parent.

## Test plan
- Reset: hold `RST` 2 cycles with `ic_req`=`dc_req`=1. All outputs must be 0 and no strobe may appear.
- IC refill, zero-wait: `ic_addr`=0x0000_1234, `mem_ack` tied 1. `mem_re` with `mem_addr` 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles. `ic_rvalid` on each, `ic_done` on the next cycle.
- Tie after reset: `ic_req`,`dc_req` both 1, `dc_we`=0. DC is served first with `dc_rvalid`×4 and `dc_done`, then IC, then DC again (alternation).
- DC write-back, 2 wait cycles per word: `dc_addr`=0x8000_0040, `dc_wdata`=0xA0+beat. `mem_we` is held 3 cycles per word with stable address/data. `dc_wready` pulses exactly 4 times and `mem_wdata` is 0xA0..0xA3.
- Reset mid-burst: assert `RST` after beat 1 ack of an IC refill. Next cycle all outputs are 0. Re-raised `ic_req` restarts at `beat` 0, addr 0x1230.
- Late addr change: change `ic_addr` to 0xFFFF_0000 after grant. All 4 `mem_addr` values stay in line 0x1230.
